// File: rtl/serial_addsub_pkg.sv
// ============================================================================
// Module   : serial_addsub_pkg
// Purpose  : Shared state encoding and sizing helpers for serial_addsub.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_addsub_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Bit-counter width; WIDTH is at least 2, so this is never zero.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_addsub_fa_cell.sv
// ============================================================================
// Module   : fa_cell
// Purpose  : Single-bit full adder used as the arithmetic core of serial_addsub.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic w_p;

  assign w_p  = a ^ b;
  assign sum  = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);

endmodule

`default_nettype wire

// File: rtl/serial_addsub.sv
// ============================================================================
// Module   : serial_addsub
// Purpose  : Bit-serial WIDTH-bit adder/subtractor, LSB first, one bit per clk.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int             c_CW   = cnt_width(WIDTH);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_load;
  logic              w_step;
  logic              w_last;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_carry;
  logic [c_CW-1:0]   r_cnt;
  logic              w_sum;
  logic              w_co;

  fa_cell u_fa (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_cnt == c_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: B is inverted on load and the +1 rides in on the carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_load) begin
        r_a     <= a;
        r_b     <= sub ? ~b : b;
        r_carry <= sub;
        r_cnt   <= '0;
        busy    <= 1'b1;
      end else if (w_step) begin
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        result  <= {w_sum, result[WIDTH-1:1]};
        r_carry <= w_co;
        r_cnt   <= r_cnt + c_CW'(1);
        if (w_last) begin
          cout     <= w_co;
          overflow <= r_carry ^ w_co;
          done     <= 1'b1;
          busy     <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub.sv
// ============================================================================
// Module   : tb_serial_addsub
// Purpose  : Self-checking bench for serial_addsub (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_addsub;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  int total;
  int bad;

  serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic msub,
                       output logic [7:0] er, output logic ec, output logic eo);
    int ua, ub, sa, sb, sr;
    ua = int'(ma);
    ub = int'(mb);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    if (msub) begin
      er = 8'(ua - ub);
      ec = (ua >= ub);
      sr = sa - sb;
    end else begin
      er = 8'(ua + ub);
      ec = (ua + ub > 255);
      sr = sa + sb;
    end
    eo = (sr > 127) || (sr < -128);
  endtask

  task automatic issue(input logic [7:0] ta, input logic [7:0] tb_, input logic ts);
    start = 1'b1;
    a     = ta;
    b     = tb_;
    sub   = ts;
    step();
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    sub   = 1'($urandom);
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = busy ? 1 : 0;
    while (!done && lat < 20) begin
      step();
      lat++;
      if (busy) bc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic ts, input logic [7:0] er, input logic ec, input logic eo);
    int lat, bc;
    issue(ta, tb_, ts);
    wait_done(lat, bc);
    chk({tag, "_latency"}, 32'(lat), 32'd8);
    chk({tag, "_busy_cycles"}, 32'(bc), 32'd8);
    chk({tag, "_result"}, 32'(result), 32'(er));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
    step();
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat, bc, dcnt, bcnt;
    logic [7:0] er, ra, rb;
    logic ec, eo, rs;

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    step();

    run_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // start pulsed three cycles into an operation must be ignored
    issue(8'h12, 8'h34, 1'b0);
    step();
    step();
    start = 1'b1;
    a     = 8'hF0;
    b     = 8'hF0;
    sub   = 1'b1;
    step();
    start = 1'b0;
    wait_done(lat, bc);
    chk("ign_latency", 32'(lat + 3), 32'd8);
    chk("ign_result", 32'(result), 32'h46);
    chk("ign_cout", 32'(cout), 32'd0);
    chk("ign_ovf", 32'(overflow), 32'd0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) dcnt++;
    end
    chk("ign_single_done", 32'(dcnt), 32'd0);

    // back-to-back: second start issued in the done cycle
    issue(8'h30, 8'h10, 1'b1);
    wait_done(lat, bc);
    chk("b2b_first_latency", 32'(lat), 32'd8);
    chk("b2b_first_result", 32'(result), 32'h20);
    chk("b2b_first_cout", 32'(cout), 32'd1);
    issue(8'h55, 8'h2A, 1'b0);
    chk("b2b_result_held", 32'(result), 32'h20);
    chk("b2b_done_cleared", 32'(done), 32'd0);
    wait_done(lat, bc);
    chk("b2b_second_latency", 32'(lat), 32'd8);
    chk("b2b_second_result", 32'(result), 32'h7F);
    chk("b2b_second_cout", 32'(cout), 32'd0);
    chk("b2b_second_ovf", 32'(overflow), 32'd0);
    step();

    // reset four cycles into RUN aborts the operation
    issue(8'hAA, 8'h55, 1'b0);
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    dcnt = 0;
    bcnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    chk("abort_no_done", 32'(dcnt), 32'd0);
    chk("abort_idle", 32'(bcnt), 32'd0);
    run_op("after_abort", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      model(ra, rb, rs, er, ec, eo);
      run_op($sformatf("rnd%0d", n), ra, rb, rs, er, ec, eo);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
